fg_cfg_dac_ctrl: RTL and testbench

FG_CFG_DAC_CTRL -- requirements
Module: fg_cfg_dac_ctrl

---
 rtl/fg_pkg.sv | 22 ++
 rtl/fg_edge_sync.sv | 37 +++
 rtl/fg_cfg_dac_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_fg_cfg_dac_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fg_pkg.sv
// ---------------------------------------------------------------------------
// fg_pkg
// Definitions shared by the function-generator config / DAC control slice:
//   - fg_state_e : DAC write sequencer states
//   - FG_*       : default values for the block parameters
// ---------------------------------------------------------------------------
package fg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } fg_state_e;

    localparam int FG_DATA_W        = 8;
    localparam int FG_ADDR_W        = 3;
    localparam int FG_SYNC_STAGES   = 2;
    localparam int FG_WR_PULSE      = 2;
    localparam int FG_SETTLE_CYCLES = 500;

endpackage

// File: rtl/fg_edge_sync.sv
// ---------------------------------------------------------------------------
// fg_edge_sync
// Brings an asynchronous strobe into the clk_i domain through SYNC_STAGES
// flops and emits a single-cycle pulse on each rising edge of the
// synchronized level, however long the strobe stays high.
//   clk_i   : system clock
//   rst_i   : synchronous active-high reset (clears all flops)
//   async_i : asynchronous strobe
//   pulse_o : one-cycle event per rising edge of async_i
// ---------------------------------------------------------------------------
module fg_edge_sync
    import fg_pkg::*;
#(
    parameter int SYNC_STAGES = FG_SYNC_STAGES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pulse_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/fg_cfg_dac_ctrl.sv
// ---------------------------------------------------------------------------
// fg_cfg_dac_ctrl
// Double-buffered configuration register bank written through asynchronous
// strobes, plus a sequencer that writes waveform samples to a parallel DAC
// with a fixed write-strobe width and a minimum settle time between writes.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   cfg_data_i/addr_i   : config write data / register address
//   cfg_wr_async_i      : async write strobe  (loads one shadow register)
//   cfg_commit_async_i  : async commit strobe (shadow bank -> active bank)
//   cfg_bus_o           : active bank, register 0 in the MSBs
//   sample_i/valid_i    : sample stream from the waveform core
//   dac_data_o          : DAC data word, stable SETUP..HOLD
//   dac_wr_n_o          : DAC write strobe, active low
//   dac_clr_n_o         : DAC clear, active low, released after reset
//   busy_o              : sequencer active or a sample pending
//   overrun_o           : sticky, a pending sample was overwritten
// ---------------------------------------------------------------------------
module fg_cfg_dac_ctrl
    import fg_pkg::*;
#(
    parameter int DATA_W        = FG_DATA_W,
    parameter int ADDR_W        = FG_ADDR_W,
    parameter int SYNC_STAGES   = FG_SYNC_STAGES,
    parameter int WR_PULSE      = FG_WR_PULSE,
    parameter int SETTLE_CYCLES = FG_SETTLE_CYCLES
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [DATA_W-1:0]               cfg_data_i,
    input  logic [ADDR_W-1:0]               cfg_addr_i,
    input  logic                            cfg_wr_async_i,
    input  logic                            cfg_commit_async_i,
    output logic [(2**ADDR_W)*DATA_W-1:0]   cfg_bus_o,
    input  logic [DATA_W-1:0]               sample_i,
    input  logic                            sample_valid_i,
    output logic [DATA_W-1:0]               dac_data_o,
    output logic                            dac_wr_n_o,
    output logic                            dac_clr_n_o,
    output logic                            busy_o,
    output logic                            overrun_o
);

    localparam int NUM_REGS = 2**ADDR_W;
    localparam int CNT_W    = $clog2(SETTLE_CYCLES + 1);

    // The counter holds the 1-based cycle index since SETUP entry, so PULSE
    // ends at index WR_PULSE+1 and HOLD releases one cycle before the
    // settle window closes (the IDLE cycle completes the window).
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] PULSE_END = CNT_W'(WR_PULSE + 1);
    localparam logic [CNT_W-1:0] HOLD_END  = CNT_W'(SETTLE_CYCLES - 1);

    logic wr_evt;
    logic commit_evt;

    fg_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (cfg_wr_async_i),
        .pulse_o (wr_evt)
    );

    fg_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_commit_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (cfg_commit_async_i),
        .pulse_o (commit_evt)
    );

    // ---- config banks -----------------------------------------------------
    logic [DATA_W-1:0] shadow_q   [NUM_REGS];
    logic [DATA_W-1:0] shadow_nxt [NUM_REGS];
    logic [DATA_W-1:0] active_q   [NUM_REGS];

    // Commit copies shadow_nxt so a write landing in the commit cycle is
    // part of the committed image.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) shadow_nxt[i] = shadow_q[i];
        if (wr_evt) shadow_nxt[cfg_addr_i] = cfg_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= shadow_nxt[i];
            if (commit_evt) begin
                for (int i = 0; i < NUM_REGS; i++) active_q[i] <= shadow_nxt[i];
            end
        end
    end

    always_comb begin
        cfg_bus_o = '0;
        for (int i = 0; i < NUM_REGS; i++)
            cfg_bus_o[(NUM_REGS-1-i)*DATA_W +: DATA_W] = active_q[i];
    end

    // ---- DAC sequencer ----------------------------------------------------
    fg_state_e         state_q, state_nxt;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] pend_data_p0;
    logic              vld_p0;
    logic              overrun_q;
    logic              load;
    logic [DATA_W-1:0] load_data;
    logic              store;
    logic              overrun_set;
    logic              clr_p0;

    always_comb begin
        state_nxt = state_q;
        load      = 1'b0;
        load_data = pend_data_p0;
        case (state_q)
            ST_IDLE: begin
                if (vld_p0) begin
                    load      = 1'b1;
                    load_data = pend_data_p0;
                    state_nxt = ST_SETUP;
                end else if (sample_valid_i) begin
                    load      = 1'b1;
                    load_data = sample_i;
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: state_nxt = ST_PULSE;
            ST_PULSE: if (cnt_q >= PULSE_END) state_nxt = ST_HOLD;
            ST_HOLD:  if (cnt_q >= HOLD_END)  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // A sample is buffered unless it goes straight to the DAC from an empty
    // IDLE; in IDLE with a pending sample the buffer is refilled as it drains.
    assign store       = sample_valid_i && !(state_q == ST_IDLE && !vld_p0);
    assign overrun_set = store && vld_p0 && (state_q != ST_IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            pend_data_p0 <= '0;
            vld_p0       <= 1'b0;
            overrun_q    <= 1'b0;
            dac_data_o   <= '0;
            dac_wr_n_o   <= 1'b1;
        end else begin
            state_q <= state_nxt;

            if (load)
                cnt_q <= CNT_W'(1);
            else if (state_q != ST_IDLE && cnt_q != CNT_MAX)
                cnt_q <= cnt_q + 1'b1;

            if (load) dac_data_o <= load_data;

            if (store) begin
                pend_data_p0 <= sample_i;
                vld_p0       <= 1'b1;
            end else if (load && vld_p0) begin
                vld_p0 <= 1'b0;
            end

            if (overrun_set)
                overrun_q <= 1'b1;
            else if (commit_evt)
                overrun_q <= 1'b0;

            dac_wr_n_o <= (state_nxt != ST_PULSE);
        end
    end

    // Clear is held one extra cycle past reset release.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clr_p0      <= 1'b0;
            dac_clr_n_o <= 1'b0;
        end else begin
            clr_p0      <= 1'b1;
            dac_clr_n_o <= clr_p0;
        end
    end

    assign busy_o    = (state_q != ST_IDLE) || vld_p0;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_fg_cfg_dac_ctrl.sv
module tb_fg_cfg_dac_ctrl;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int BW = (2**AW) * DW;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [DW-1:0] cfg_data_i;
    logic [AW-1:0] cfg_addr_i;
    logic          cfg_wr_async_i;
    logic          cfg_commit_async_i;
    logic [BW-1:0] cfg_bus_o;
    logic [DW-1:0] sample_i;
    logic          sample_valid_i;
    logic [DW-1:0] dac_data_o;
    logic          dac_wr_n_o;
    logic          dac_clr_n_o;
    logic          busy_o;
    logic          overrun_o;

    fg_cfg_dac_ctrl #(
        .DATA_W(DW), .ADDR_W(AW), .SYNC_STAGES(2), .WR_PULSE(2), .SETTLE_CYCLES(500)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .cfg_data_i         (cfg_data_i),
        .cfg_addr_i         (cfg_addr_i),
        .cfg_wr_async_i     (cfg_wr_async_i),
        .cfg_commit_async_i (cfg_commit_async_i),
        .cfg_bus_o          (cfg_bus_o),
        .sample_i           (sample_i),
        .sample_valid_i     (sample_valid_i),
        .dac_data_o         (dac_data_o),
        .dac_wr_n_o         (dac_wr_n_o),
        .dac_clr_n_o        (dac_clr_n_o),
        .busy_o             (busy_o),
        .overrun_o          (overrun_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records each DAC write (data at strobe fall) and strobe width.
    logic [DW-1:0] obs_q[$];
    int            len_q[$];
    logic          wr_prev = 1'b1;
    int            low_cnt = 0;
    always @(negedge clk) begin
        if (wr_prev && !dac_wr_n_o) obs_q.push_back(dac_data_o);
        if (!wr_prev && dac_wr_n_o) len_q.push_back(low_cnt);
        low_cnt <= dac_wr_n_o ? 0 : low_cnt + 1;
        wr_prev <= dac_wr_n_o;
    end

    logic [DW-1:0] exp_q[$];
    int            exp_len_q[$];
    int            obs_rd = 0;
    int            len_rd = 0;
    int            total = 0;
    int            bad = 0;
    int            t0 = 0;
    logic [BW-1:0] bus_exp = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int k);
        while (cyc < t0 + k) tick();
    endtask

    task automatic test_reset();
        rst_i = 1'b1; cfg_data_i = '0; cfg_addr_i = '0; cfg_wr_async_i = 1'b0;
        cfg_commit_async_i = 1'b0; sample_i = '0; sample_valid_i = 1'b0;
        repeat (3) tick();
        total++; if (dac_wr_n_o !== 1'b1) begin bad++; $display("FAIL reset_wr_n got=%b exp=1", dac_wr_n_o); end
        total++; if (dac_clr_n_o !== 1'b0) begin bad++; $display("FAIL reset_clr_n got=%b exp=0", dac_clr_n_o); end
        total++; if (dac_data_o !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", dac_data_o); end
        total++; if (cfg_bus_o !== '0) begin bad++; $display("FAIL reset_bus got=%h exp=0", cfg_bus_o); end
        total++; if (busy_o !== 1'b0 || overrun_o !== 1'b0) begin bad++; $display("FAIL reset_flags got busy=%b ovr=%b exp=0/0", busy_o, overrun_o); end
        rst_i = 1'b0;
        tick();
        total++; if (dac_clr_n_o !== 1'b0) begin bad++; $display("FAIL clr_hold got=%b exp=0", dac_clr_n_o); end
        tick();
        total++; if (dac_clr_n_o !== 1'b1) begin bad++; $display("FAIL clr_release got=%b exp=1", dac_clr_n_o); end
    endtask

    task automatic test_cfg_write();
        int errs = 0;
        cfg_addr_i = 3'd3; cfg_data_i = 8'hA5; cfg_wr_async_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cfg_bus_o !== bus_exp) errs++;
        end
        cfg_wr_async_i = 1'b0;
        repeat (4) tick();
        total++; if (errs != 0 || cfg_bus_o !== bus_exp) begin bad++; $display("FAIL write_no_commit got=%h exp=%h", cfg_bus_o, bus_exp); end
    endtask

    task automatic test_commit();
        t0 = cyc;
        cfg_commit_async_i = 1'b1;
        wait_to(2);
        total++; if (cfg_bus_o !== bus_exp) begin bad++; $display("FAIL commit_early got=%h exp=%h", cfg_bus_o, bus_exp); end
        bus_exp = 64'h0000_00A5_0000_0000;
        wait_to(3);
        total++; if (cfg_bus_o !== bus_exp) begin bad++; $display("FAIL commit_visible got=%h exp=%h", cfg_bus_o, bus_exp); end
        wait_to(6);
        cfg_commit_async_i = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_write_commit_same();
        t0 = cyc;
        cfg_addr_i = 3'd0; cfg_data_i = 8'h5A;
        cfg_wr_async_i = 1'b1; cfg_commit_async_i = 1'b1;
        wait_to(2);
        total++; if (cfg_bus_o !== bus_exp) begin bad++; $display("FAIL same_early got=%h exp=%h", cfg_bus_o, bus_exp); end
        bus_exp = 64'h5A00_00A5_0000_0000;
        wait_to(3);
        total++; if (cfg_bus_o !== bus_exp) begin bad++; $display("FAIL same_visible got=%h exp=%h", cfg_bus_o, bus_exp); end
        wait_to(6);
        cfg_wr_async_i = 1'b0; cfg_commit_async_i = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_dac_single();
        t0 = cyc;
        sample_i = 8'h80; sample_valid_i = 1'b1;
        exp_q.push_back(8'h80); exp_len_q.push_back(2);
        wait_to(1);
        sample_valid_i = 1'b0;
        total++; if (dac_data_o !== 8'h80 || dac_wr_n_o !== 1'b1) begin bad++; $display("FAIL dac_setup got data=%h wr_n=%b exp 80/1", dac_data_o, dac_wr_n_o); end
        wait_to(2);
        total++; if (dac_wr_n_o !== 1'b0) begin bad++; $display("FAIL dac_pulse_c2 got=%b exp=0", dac_wr_n_o); end
        wait_to(3);
        total++; if (dac_wr_n_o !== 1'b0) begin bad++; $display("FAIL dac_pulse_c3 got=%b exp=0", dac_wr_n_o); end
        wait_to(4);
        total++; if (dac_wr_n_o !== 1'b1 || busy_o !== 1'b1) begin bad++; $display("FAIL dac_hold got wr_n=%b busy=%b exp 1/1", dac_wr_n_o, busy_o); end
    endtask

    // Continues the transaction started by test_dac_single (same t0).
    task automatic test_overrun();
        wait_to(10);
        sample_i = 8'h10; sample_valid_i = 1'b1;
        wait_to(11);
        sample_i = 8'h20;
        wait_to(12);
        sample_i = 8'h30;
        exp_q.push_back(8'h30); exp_len_q.push_back(2);
        wait_to(13);
        sample_valid_i = 1'b0;
        total++; if (overrun_o !== 1'b1) begin bad++; $display("FAIL overrun_set got=%b exp=1", overrun_o); end
        wait_to(500);
        total++; if (dac_data_o !== 8'h80) begin bad++; $display("FAIL settle_early got=%h exp=80", dac_data_o); end
        wait_to(501);
        total++; if (dac_data_o !== 8'h30 || dac_wr_n_o !== 1'b1) begin bad++; $display("FAIL pending_setup got data=%h wr_n=%b exp 30/1", dac_data_o, dac_wr_n_o); end
        wait_to(502);
        total++; if (dac_wr_n_o !== 1'b0) begin bad++; $display("FAIL pending_pulse got=%b exp=0", dac_wr_n_o); end
        wait_to(510);
        total++; if (overrun_o !== 1'b1) begin bad++; $display("FAIL overrun_sticky got=%b exp=1", overrun_o); end
        t0 = cyc;
        cfg_commit_async_i = 1'b1;
        wait_to(3);
        total++; if (overrun_o !== 1'b0 || cfg_bus_o !== bus_exp) begin bad++; $display("FAIL commit_clear got ovr=%b bus=%h exp 0/%h", overrun_o, cfg_bus_o, bus_exp); end
        cfg_commit_async_i = 1'b0;
        begin
            int n = 0;
            while (busy_o === 1'b1 && n < 1000) begin tick(); n++; end
            total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL idle_timeout got busy=%b exp=0", busy_o); end
        end
    endtask

    task automatic test_reset_mid_pulse();
        int nobs;
        repeat (2) tick();
        t0 = cyc;
        sample_i = 8'h77; sample_valid_i = 1'b1;
        exp_q.push_back(8'h77); exp_len_q.push_back(1);
        wait_to(1);
        sample_i = 8'h66;
        wait_to(2);
        sample_valid_i = 1'b0;
        total++; if (dac_wr_n_o !== 1'b0) begin bad++; $display("FAIL mid_pulse_low got=%b exp=0", dac_wr_n_o); end
        rst_i = 1'b1;
        wait_to(3);
        total++; if (dac_wr_n_o !== 1'b1 || dac_data_o !== 8'h00) begin bad++; $display("FAIL mid_rst_out got wr_n=%b data=%h exp 1/00", dac_wr_n_o, dac_data_o); end
        total++; if (dac_clr_n_o !== 1'b0 || busy_o !== 1'b0 || cfg_bus_o !== '0) begin bad++; $display("FAIL mid_rst_state got clr=%b busy=%b bus=%h exp 0/0/0", dac_clr_n_o, busy_o, cfg_bus_o); end
        wait_to(4);
        rst_i = 1'b0;
        wait_to(5);
        total++; if (dac_clr_n_o !== 1'b0) begin bad++; $display("FAIL mid_clr_hold got=%b exp=0", dac_clr_n_o); end
        wait_to(6);
        total++; if (dac_clr_n_o !== 1'b1) begin bad++; $display("FAIL mid_clr_release got=%b exp=1", dac_clr_n_o); end
        nobs = obs_q.size();
        wait_to(30);
        total++; if (obs_q.size() != nobs || busy_o !== 1'b0 || dac_wr_n_o !== 1'b1) begin bad++; $display("FAIL pending_dropped got writes=%0d busy=%b exp writes=%0d busy=0", obs_q.size(), busy_o, nobs); end
    endtask

    task automatic test_scoreboard();
        while (exp_q.size() > 0) begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            total++;
            if (obs_rd >= obs_q.size()) begin bad++; $display("FAIL dac_word missing exp=%h", e); end
            else begin
                if (obs_q[obs_rd] !== e) begin bad++; $display("FAIL dac_word got=%h exp=%h", obs_q[obs_rd], e); end
                obs_rd++;
            end
        end
        total++; if (obs_rd != obs_q.size()) begin bad++; $display("FAIL dac_extra got=%0d writes exp=%0d", obs_q.size(), obs_rd); end
        while (exp_len_q.size() > 0) begin
            int el;
            el = exp_len_q.pop_front();
            total++;
            if (len_rd >= len_q.size()) begin bad++; $display("FAIL pulse_len missing exp=%0d", el); end
            else begin
                if (len_q[len_rd] != el) begin bad++; $display("FAIL pulse_len got=%0d exp=%0d", len_q[len_rd], el); end
                len_rd++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_cfg_write();
        test_commit();
        test_write_commit_same();
        test_dac_single();
        test_overrun();
        test_reset_mid_pulse();
        test_scoreboard();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
